// File: rtl/ad7606_frame_packer.sv
// AD7606 frame packer: 2-deep sample buffer, streams {A5,fcnt}, CH1..CH8 over valid/ready; one registered output stage.
// Define AD7606_PACK_CHECKSUM_EN to append an XOR checksum word (carries m_last_o) to every frame.
module ad7606_frame_packer #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         FCNT_W      = 8,
  parameter int         OVF_CNT_W   = 16
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 data_flag_i,
  input  logic [15:0]          ch1_data_i,
  input  logic [15:0]          ch2_data_i,
  input  logic [15:0]          ch3_data_i,
  input  logic [15:0]          ch4_data_i,
  input  logic [15:0]          ch5_data_i,
  input  logic [15:0]          ch6_data_i,
  input  logic [15:0]          ch7_data_i,
  input  logic [15:0]          ch8_data_i,
  output logic [15:0]          m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic                 ovf_o,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o,
  input  logic                 clr_ovf_i
);

  typedef struct packed {
    logic [FCNT_W-1:0] fcnt;
    logic [7:0][15:0]  ch;
  } sample_t;

`ifdef AD7606_PACK_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_CH, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_CH} state_t;
`endif

  logic                 flag_q;
  logic [FCNT_W-1:0]    fcnt_q;
  logic [1:0]           wr_ptr_q;
  logic [1:0]           rd_ptr_q;
  sample_t              buf_q [2];
  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [15:0]          data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic                 ovf_q;
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  logic    capture, buf_empty, buf_full, inflight, last_hs, accept, drop, out_free;
  sample_t cur;
  logic [15:0] hdr_word;

  assign capture   = data_flag_i & ~flag_q;
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);
  // The last word of a frame can still sit in the output register after the FSM moved on;
  // its buffer entry stays owned until that word is accepted.
  assign inflight  = vld_q & last_q;
  assign last_hs   = vld_q & last_q & m_ready_i;
  assign accept    = capture & (~buf_full | last_hs);
  assign drop      = capture & ~accept;
  assign out_free  = ~vld_q | m_ready_i;
  assign cur       = buf_q[rd_ptr_q[0] ^ inflight];
  assign hdr_word  = {HEADER_BYTE, cur.fcnt};

`ifdef AD7606_PACK_CHECKSUM_EN
  logic [15:0] csum_word;
  always_comb begin
    csum_word = hdr_word;
    for (int i = 0; i < 8; i++) csum_word ^= cur.ch[i];
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    vld_d   = vld_q & ~m_ready_i;
    case (state_q)
      ST_IDLE: begin
        if (inflight ? buf_full : ~buf_empty) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (out_free) begin
          vld_d   = 1'b1;
          data_d  = hdr_word;
          last_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = ST_CH;
        end
      end
      ST_CH: begin
        if (out_free) begin
          vld_d  = 1'b1;
          data_d = cur.ch[idx_q];
          last_d = 1'b0;
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef AD7606_PACK_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            last_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef AD7606_PACK_CHECKSUM_EN
      ST_CSUM: begin
        if (out_free) begin
          vld_d   = 1'b1;
          data_d  = csum_word;
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      flag_q    <= 1'b0;
      fcnt_q    <= '0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      data_q    <= 16'd0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      flag_q  <= data_flag_i;
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      if (capture) fcnt_q   <= fcnt_q + FCNT_W'(1);
      if (accept)  wr_ptr_q <= wr_ptr_q + 2'd1;
      if (last_hs) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (clr_ovf_i) begin
        ovf_q     <= 1'b0;
        ovf_cnt_q <= '0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (~&ovf_cnt_q) ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge sys_clk_i) begin
    if (accept) begin
      buf_q[wr_ptr_q[0]] <= {fcnt_q, ch8_data_i, ch7_data_i, ch6_data_i, ch5_data_i,
                             ch4_data_i, ch3_data_i, ch2_data_i, ch1_data_i};
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = vld_q;
  assign m_last_o  = last_q;
  assign busy_o    = (state_q != ST_IDLE) | ~buf_empty;
  assign ovf_o     = ovf_q;
  assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_ad7606_frame_packer.sv
// Scoreboard bench for ad7606_frame_packer: stimulus pushes expected words, a negedge monitor pops on handshake.
module tb_ad7606_frame_packer;

  logic        clk = 1'b0;
  logic        rst, flag, m_ready, clr;
  logic [15:0] ch [8];
  logic [15:0] m_data_o;
  logic        m_valid_o, m_last_o, busy_o, ovf_o;
  logic [15:0] ovf_cnt_o;

  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;
  logic [16:0] exp_q [$];
  logic [16:0] mon_exp;
  logic        stall_q = 1'b0;
  logic [15:0] stall_dat = 16'd0;
  logic        stall_last = 1'b0;

  always #5 clk = ~clk;

  ad7606_frame_packer dut (
    .sys_clk_i  (clk),
    .rst_i      (rst),
    .data_flag_i(flag),
    .ch1_data_i (ch[0]),
    .ch2_data_i (ch[1]),
    .ch3_data_i (ch[2]),
    .ch4_data_i (ch[3]),
    .ch5_data_i (ch[4]),
    .ch6_data_i (ch[5]),
    .ch7_data_i (ch[6]),
    .ch8_data_i (ch[7]),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready),
    .m_last_o   (m_last_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o),
    .ovf_cnt_o  (ovf_cnt_o),
    .clr_ovf_i  (clr)
  );

  // Sink ready pattern: 0 = stalled, 1 = always ready, 2 = toggling every cycle.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ~m_ready;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          tests++;
          if (!m_valid_o || m_data_o !== stall_dat || m_last_o !== stall_last) begin
            fails++;
            $display("FAIL stall_hold: got vld=%0b dat=%h last=%0b, required vld=1 dat=%h last=%0b",
                     m_valid_o, m_data_o, m_last_o, stall_dat, stall_last);
          end
        end
        if (m_valid_o && m_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL word: got dat=%h last=%0b, required no word", m_data_o, m_last_o);
          end else begin
            mon_exp = exp_q.pop_front();
            if ({m_last_o, m_data_o} !== mon_exp) begin
              fails++;
              $display("FAIL word: got dat=%h last=%0b, required dat=%h last=%0b",
                       m_data_o, m_last_o, mon_exp[15:0], mon_exp[16]);
            end
          end
        end
        stall_q    = m_valid_o && !m_ready;
        stall_dat  = m_data_o;
        stall_last = m_last_o;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic set_ch(input logic [15:0] base);
    for (int i = 0; i < 8; i++) ch[i] = base + 16'(i);
  endtask

  task automatic push_frame(input logic [7:0] fc, input logic [15:0] base);
    logic [15:0] w;
    logic [15:0] cs;
    logic        lastch;
    cs = {8'hA5, fc};
    exp_q.push_back({1'b0, 8'hA5, fc});
    for (int i = 0; i < 8; i++) begin
      w  = base + 16'(i);
      cs = cs ^ w;
`ifdef AD7606_PACK_CHECKSUM_EN
      lastch = 1'b0;
`else
      lastch = (i == 7);
`endif
      exp_q.push_back({lastch, w});
    end
`ifdef AD7606_PACK_CHECKSUM_EN
    exp_q.push_back({1'b1, cs});
`endif
  endtask

  task automatic pulse(input logic [15:0] base);
    set_ch(base);
    @(posedge clk); #1;
    flag = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    flag = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int mode);
    @(posedge clk); #1;
    rst = 1'b1; flag = 1'b0; clr = 1'b0; rdy_mode = mode;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid_o || busy_o) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 1000) begin
      fails++;
      $display("FAIL drain_%s: got %0d words outstanding busy=%0b, required 0 and idle", nm, exp_q.size(), busy_o);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; flag = 1'b0; clr = 1'b0;
    set_ch(16'h0000);

    // Test 1: single frame, ready held, latency and reset state
    do_reset(1);
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_last",  32'(m_last_o), 0);
    chk("rst_data",  32'(m_data_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_ovf",   32'(ovf_o), 0);
    chk("rst_cnt",   32'(ovf_cnt_o), 0);
    exp_q.push_back({1'b0, 16'hA500});
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0002});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0004});
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h0006});
    exp_q.push_back({1'b0, 16'h0007});
`ifdef AD7606_PACK_CHECKSUM_EN
    exp_q.push_back({1'b0, 16'h0008});
    exp_q.push_back({1'b1, 16'hA508});
`else
    exp_q.push_back({1'b1, 16'h0008});
`endif
    set_ch(16'h0001);
    @(posedge clk); #1;
    flag = 1'b1;
    @(posedge clk); #1;
    chk("t1_valid_n",  32'(m_valid_o), 0);
    chk("t1_busy_n",   32'(busy_o), 1);
    @(posedge clk); #1;
    chk("t1_valid_n1", 32'(m_valid_o), 0);
    @(posedge clk); #1;
    chk("t1_valid_n2", 32'(m_valid_o), 1);
    chk("t1_hdr_n2",   32'(m_data_o), 32'hA500);
    flag = 1'b0;
    drain("t1");

    // Test 2: toggling ready, same word sequence
    do_reset(2);
    push_frame(8'h00, 16'h0001);
    pulse(16'h0001);
    drain("t2");

    // Test 3: stalled sink, third capture dropped, header numbering gap
    do_reset(0);
    push_frame(8'h00, 16'h0100);
    push_frame(8'h01, 16'h0200);
    pulse(16'h0100);
    pulse(16'h0200);
    chk("t3_ovf_before", 32'(ovf_o), 0);
    chk("t3_cnt_before", 32'(ovf_cnt_o), 0);
    pulse(16'h0300);
    chk("t3_ovf_after",  32'(ovf_o), 1);
    chk("t3_cnt_after",  32'(ovf_cnt_o), 1);
    chk("t3_busy",       32'(busy_o), 1);
    rdy_mode = 1;
    drain("t3a");
    push_frame(8'h03, 16'h0400);
    pulse(16'h0400);
    drain("t3b");
    chk("t3_cnt_kept",   32'(ovf_cnt_o), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t3_ovf_clr",    32'(ovf_o), 0);
    chk("t3_cnt_clr",    32'(ovf_cnt_o), 0);

    // Test 4: capture on the same edge as the last-word handshake of a full buffer
    do_reset(0);
    push_frame(8'h00, 16'h1000);
    push_frame(8'h01, 16'h2000);
    pulse(16'h1000);
    pulse(16'h2000);
    rdy_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid_o && m_last_o && m_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_last_seen", 32'(found), 1);
    if (found) begin
      #1;
      set_ch(16'h3000);
      flag = 1'b1;
      push_frame(8'h02, 16'h3000);
      @(posedge clk); #1;
      chk("t4_ovf", 32'(ovf_o), 0);
      chk("t4_cnt", 32'(ovf_cnt_o), 0);
      flag = 1'b0;
    end
    drain("t4");

    // Test 5: reset while CH4 is presented
    do_reset(1);
    exp_q.push_back({1'b0, 16'hA500});
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0002});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0004});
    pulse(16'h0001);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_valid_o && m_data_o == 16'h0004) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_ch4_seen", 32'(found), 1);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid", 32'(m_valid_o), 0);
    chk("t5_last",  32'(m_last_o), 0);
    chk("t5_data",  32'(m_data_o), 0);
    chk("t5_busy",  32'(busy_o), 0);
    rst = 1'b0;
    chk("t5_words_left", 32'(exp_q.size()), 0);
    push_frame(8'h00, 16'h0500);
    pulse(16'h0500);
    drain("t5");

    // Test 7: flag already high when reset releases captures exactly once
    @(posedge clk); #1;
    rst = 1'b1; rdy_mode = 1;
    set_ch(16'h0600);
    flag = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    push_frame(8'h00, 16'h0600);
    repeat (20) begin @(posedge clk); #1; end
    flag = 1'b0;
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
